// File: rtl/lat_mem_pkg.sv
// Shared types and parameter helpers for the latency-configurable memory.
// Keeps the address-offset and index-width arithmetic in one place.
package lat_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Number of low byte-address bits that select a byte within a word.
  function automatic int byte_off(input int width);
    return $clog2(width / 8);
  endfunction

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_width(input int latency);
    return (latency > 1) ? $clog2(latency) : 1;
  endfunction

endpackage

// File: rtl/lat_mem_be_merge.sv
// Byte-lane merge: each lane takes the new data when its enable is set,
// otherwise it keeps the old word's lane.
module lat_mem_be_merge #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   old_word,
  input  logic [WIDTH-1:0]   new_word,
  input  logic [WIDTH/8-1:0] be,
  output logic [WIDTH-1:0]   merged
);

  generate
    for (genvar gi = 0; gi < WIDTH / 8; gi++) begin : g_lane
      assign merged[8*gi +: 8] = be[gi] ? new_word[8*gi +: 8] : old_word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/lat_mem.sv
// Word memory with configurable response latency, byte-lane writes, busy
// indication and out-of-range reporting behind a request/done handshake.
module lat_mem
  import lat_mem_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int ADDRSIZE = 32,
  parameter int DEPTH    = 1024,
  parameter int LATENCY  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_r,
  input  logic                mem_w,
  input  logic [ADDRSIZE-1:0] data_addr,
  input  logic [WIDTH-1:0]    data_in,
  input  logic [WIDTH/8-1:0]  byte_en,
  output logic [WIDTH-1:0]    data_out,
  output logic                mem_done,
  output logic                busy,
  output logic                addr_err
);

  localparam int OFF   = byte_off(WIDTH);
  localparam int IDX_W = idx_width(DEPTH);
  localparam int CNT_W = cnt_width(LATENCY);
  localparam int NB    = WIDTH / 8;

  // Named in capitals so benches can preload it hierarchically.
  logic [WIDTH-1:0] MEM [0:DEPTH-1];

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [IDX_W-1:0]  idx_reg;
  logic              oor_reg;
  logic              wr_reg;
  logic              rd_reg;
  logic [WIDTH-1:0]  wdata_reg;
  logic [NB-1:0]     be_reg;

  logic [ADDRSIZE-1:0] word_addr;
  logic [IDX_W-1:0]    word_idx;
  logic                word_oor;
  logic                accept;
  logic                complete;
  logic                mem_we;
  logic                done_next;
  logic                err_next;
  logic [WIDTH-1:0]    old_word;
  logic [WIDTH-1:0]    merged;
  logic [WIDTH-1:0]    data_out_next;

  // Range check uses the full word address so high bits cannot alias low words.
  assign word_addr = data_addr >> OFF;
  assign word_idx  = word_addr[IDX_W-1:0];
  assign word_oor  = 64'(word_addr) >= 64'(DEPTH);

  assign accept   = (state_reg == IDLE) && (mem_r || mem_w);
  assign complete = (state_reg == WAIT) && (cnt_reg == '0);
  assign busy     = (state_reg == WAIT);

  assign old_word = MEM[idx_reg];

  lat_mem_be_merge #(
    .WIDTH(WIDTH)
  ) u_merge (
    .old_word(old_word),
    .new_word(wdata_reg),
    .be      (be_reg),
    .merged  (merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      oor_reg   <= 1'b0;
      wr_reg    <= 1'b0;
      rd_reg    <= 1'b0;
      wdata_reg <= '0;
      be_reg    <= '0;
      data_out  <= '0;
      mem_done  <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      data_out  <= data_out_next;
      mem_done  <= done_next;
      addr_err  <= err_next;
      if (accept) begin
        idx_reg   <= word_idx;
        oor_reg   <= word_oor;
        wr_reg    <= mem_w;
        rd_reg    <= mem_r;
        wdata_reg <= data_in;
        be_reg    <= byte_en;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (mem_r || mem_w) begin
          state_next = WAIT;
          cnt_next   = CNT_W'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A combined read+write returns the merged word; a plain write leaves data_out alone.
  always_comb begin
    mem_we        = complete && wr_reg && !oor_reg && !rst;
    done_next     = complete;
    err_next      = complete && oor_reg;
    data_out_next = data_out;
    if (complete && rd_reg) begin
      if (oor_reg) begin
        data_out_next = '0;
      end else if (wr_reg) begin
        data_out_next = merged;
      end else begin
        data_out_next = old_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      MEM[idx_reg] <= merged;
    end
  end

endmodule

// File: tb/tb_lat_mem.sv
// Directed bench for lat_mem: table of single transactions on a LATENCY=2
// instance plus hand sequences for reset, ignored and held requests.
module tb_lat_mem;

  localparam int LAT  = 2;
  localparam int LAT1 = 1;

  logic        clk;
  logic        rst = 1'b0;
  logic        mem_r, mem_w;
  logic [31:0] data_addr, data_in;
  logic [3:0]  byte_en;
  logic [31:0] data_out;
  logic        mem_done, busy, addr_err;

  logic        r1, w1;
  logic [31:0] a1, d1;
  logic [3:0]  be1;
  logic [31:0] dout1;
  logic        done1, busy1, err1;

  int checks = 0;
  int errors = 0;

  lat_mem #(.WIDTH(32), .ADDRSIZE(32), .DEPTH(1024), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .mem_r(mem_r), .mem_w(mem_w), .data_addr(data_addr),
    .data_in(data_in), .byte_en(byte_en), .data_out(data_out),
    .mem_done(mem_done), .busy(busy), .addr_err(addr_err)
  );

  lat_mem #(.WIDTH(32), .ADDRSIZE(32), .DEPTH(1024), .LATENCY(LAT1)) dut1 (
    .clk(clk), .rst(rst), .mem_r(r1), .mem_w(w1), .data_addr(a1),
    .data_in(d1), .byte_en(be1), .data_out(dout1),
    .mem_done(done1), .busy(busy1), .addr_err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] addr;
    logic [31:0] din;
    logic [3:0]  be;
    logic [31:0] exp_dout;
    logic        exp_err;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // One request on dut: drive, wait (bounded) for mem_done, drop, confirm the pulse ended.
  task automatic req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, output logic [31:0] dout, output logic err);
    int lat;
    @(negedge clk);
    mem_r = r; mem_w = w; data_addr = a; data_in = d; byte_en = be;
    @(posedge clk); #1;
    check("busy_after_accept", 32'(busy), 32'd1);
    lat = 0;
    while (lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (mem_done) break;
    end
    check("done_latency", 32'(lat), 32'(LAT));
    check("busy_at_done", 32'(busy), 32'd0);
    dout = data_out;
    err  = addr_err;
    @(negedge clk);
    mem_r = 1'b0; mem_w = 1'b0;
    @(posedge clk); #1;
    check("done_one_cycle", 32'(mem_done), 32'd0);
    check("err_one_cycle", 32'(addr_err), 32'd0);
    $display("req r=%0b w=%0b addr=0x%08h din=0x%08h be=%b -> dout=0x%08h err=%0b lat=%0d",
             r, w, a, d, be, dout, err, lat);
  endtask

  initial begin
    logic [31:0] dout;
    logic        err;

    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,          4'h0, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h11223344,   4'b0101, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,          4'h0, 32'hAA22CC44, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,          4'h0, 32'hAA22CC44, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,          4'h0, 32'h00000000, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_1000, 32'hFFFFFFFF,   4'hF, 32'h00000000, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,          4'h0, 32'h5A5A5A5A, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0001_0000, 32'h0,          4'h0, 32'h00000000, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,          4'h0, 32'hDEADBEEF, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,          4'h0, 32'hDEADBEEF, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,          4'h0, 32'hAA22CC44, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 32'h0000_0008, 32'h12345678,   4'hF, 32'h12345678, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,          4'h0, 32'h12345678, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 32'h0000_0010, 32'h77000000,   4'b1000, 32'h12345678, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,          4'h0, 32'h7722CC44, 1'b0};

    mem_r = 1'b0; mem_w = 1'b0; data_addr = '0; data_in = '0; byte_en = '0;
    r1 = 1'b0; w1 = 1'b0; a1 = '0; d1 = '0; be1 = '0;

    // Power-on reset, asserted between clock edges.
    #1 rst = 1'b1;
    #1;
    check("rst_data_out", data_out, 32'h0);
    check("rst_mem_done", 32'(mem_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    #10 rst = 1'b0;

    // Preload through the port; plain writes must leave data_out untouched.
    req(1'b0, 1'b1, 32'h0000_0000, 32'hDEADBEEF, 4'hF, dout, err);
    req(1'b0, 1'b1, 32'h0000_0010, 32'hAABBCCDD, 4'hF, dout, err);
    req(1'b0, 1'b1, 32'h0000_0020, 32'h01020304, 4'hF, dout, err);
    req(1'b0, 1'b1, 32'h0000_0024, 32'h00000000, 4'hF, dout, err);
    req(1'b0, 1'b1, 32'h0000_0008, 32'h00000000, 4'hF, dout, err);
    req(1'b0, 1'b1, 32'h0000_0FFC, 32'h5A5A5A5A, 4'hF, dout, err);
    check("preload_dout_held", dout, 32'h0);
    check("preload_err", 32'(err), 32'd0);

    for (int i = 0; i < 15; i++) begin
      req(vecs[i].r, vecs[i].w, vecs[i].addr, vecs[i].din, vecs[i].be, dout, err);
      check($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
    end

    // Reset in the middle of a write: aborted, no done, array keeps old data.
    @(negedge clk);
    mem_w = 1'b1; data_addr = 32'h20; data_in = 32'hCAFEF00D; byte_en = 4'hF;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("abort_data_out", data_out, 32'h0);
    check("abort_busy_low", 32'(busy), 32'd0);
    check("abort_done_low", 32'(mem_done), 32'd0);
    mem_w = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("abort_no_done%0d", i), 32'(mem_done), 32'd0);
    end
    req(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'h0, dout, err);
    check("abort_old_value", dout, 32'h01020304);
    req(1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'h0, dout, err);
    check("reset_keeps_array", dout, 32'hDEADBEEF);

    // Requests changing during WAIT are ignored; the captured write commits once.
    @(negedge clk);
    mem_w = 1'b1; data_addr = 32'h20; data_in = 32'hAAAA0001; byte_en = 4'hF;
    @(posedge clk); #1;
    check("toggle_busy", 32'(busy), 32'd1);
    @(negedge clk);
    mem_w = 1'b0; data_addr = 32'h24; data_in = 32'hBBBB0002;
    #2 mem_w = 1'b1;
    @(posedge clk); #1;
    check("toggle_no_early_done", 32'(mem_done), 32'd0);
    @(posedge clk); #1;
    check("toggle_done", 32'(mem_done), 32'd1);
    @(negedge clk);
    mem_w = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("toggle_idle%0d", i), 32'(busy | mem_done), 32'd0);
    end
    req(1'b1, 1'b0, 32'h0000_0024, 32'h0, 4'h0, dout, err);
    check("toggle_no_extra_write", dout, 32'h0);
    req(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'h0, dout, err);
    check("toggle_captured_write", dout, 32'hAAAA0001);

    // LATENCY=1 instance: a held read completes every second cycle.
    @(negedge clk);
    w1 = 1'b1; a1 = 32'h4; d1 = 32'h0BADCAFE; be1 = 4'hF;
    @(posedge clk); #1;
    check("l1_write_busy", 32'(busy1), 32'd1);
    @(posedge clk); #1;
    check("l1_write_done", 32'(done1), 32'd1);
    @(negedge clk);
    w1 = 1'b0; r1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check($sformatf("held_done%0d", i), 32'(done1), 32'(i % 2 == 1));
      check($sformatf("held_busy%0d", i), 32'(busy1), 32'(i % 2 == 0));
      if (i % 2 == 1) check($sformatf("held_dout%0d", i), dout1, 32'h0BADCAFE);
      $display("held read cycle %0d: done=%0b busy=%0b dout=0x%08h", i, done1, busy1, dout1);
    end
    @(negedge clk);
    r1 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule
